// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Serialises one word per frame as
// start(0), data LSB-first, optional parity, stop(1). Each bit is held for
// 'prescale' clocks (0 is treated as 1).
// Ports:
//   clk_based_on_prescale  oversampled clock, all logic on posedge
//   rst_n                  synchronous active-low reset
//   tx_data / data_valid   host word and its valid; accepted when tx_ready
//   parity_enable          1 = insert parity bit
//   parity_type            0 = even, 1 = odd
//   prescale               clocks per bit
//   tx_ready               idle, can accept a word (registered)
//   busy                   frame in progress (registered, = ~tx_ready)
//   tx_out                 serial line, idle high (registered)
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      clk_based_on_prescale,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      data_valid,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_ready,
  output logic                      busy,
  output logic                      tx_out
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned PW    = PRESCALE_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state;
  state_t state_next;

  logic [PW-1:0]         cnt;
  logic [PW-1:0]         presc_q;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit_q;

  logic accept;
  logic bit_end;
  logic tx_out_d;
  logic tx_ready_d;

  assign accept  = (state == S_IDLE) && data_valid;
  // Last clock of the current bit time.
  assign bit_end = (cnt == (presc_q - PW'(1)));

  // State register.
  always_ff @(posedge clk_based_on_prescale) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (data_valid) state_next = S_START;
      S_START:  if (bit_end)    state_next = S_DATA;
      S_DATA:   if (bit_end && (idx == LAST_IDX))
                  state_next = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end)    state_next = S_STOP;
      S_STOP:   if (bit_end)    state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
  end

  // Data bit index for the bit that will be on the line after this edge.
  always_comb begin
    idx_next = '0;
    if (state == S_DATA) begin
      if (bit_end) idx_next = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      else         idx_next = idx;
    end
  end

  // Output logic: line level and ready for the state being entered, so the
  // registered outputs change on the same edge as the state.
  always_comb begin
    tx_out_d   = 1'b1;
    tx_ready_d = (state_next == S_IDLE);
    case (state_next)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = data_q[idx_next];
      S_PARITY: tx_out_d = par_bit_q;
      default:  tx_out_d = 1'b1;
    endcase
  end

  // Frame configuration latch and bit timing counters.
  always_ff @(posedge clk_based_on_prescale) begin
    if (!rst_n) begin
      cnt       <= '0;
      presc_q   <= '0;
      idx       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q    <= tx_data;
        par_en_q  <= parity_enable;
        par_bit_q <= (^tx_data) ^ parity_type;
        presc_q   <= (prescale == '0) ? PW'(1) : prescale;
        cnt       <= '0;
      end else if (state != S_IDLE) begin
        cnt <= bit_end ? '0 : cnt + PW'(1);
      end
      idx <= idx_next;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_based_on_prescale) begin
    if (!rst_n) begin
      tx_out   <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      tx_out   <= tx_out_d;
      tx_ready <= tx_ready_d;
      busy     <= ~tx_ready_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: cycle-exact frame checks plus a
// mid-bit sampling receiver model for random loopback words.
module tb_uart_tx_frame;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tx_data;
  logic          data_valid;
  logic          parity_enable;
  logic          parity_type;
  logic [PW-1:0] prescale;
  logic          tx_ready;
  logic          busy;
  logic          tx_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] nxt_data;
  logic       nxt_pe;
  logic       nxt_pt;
  logic [5:0] nxt_ps;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk_based_on_prescale(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .data_valid(data_valid),
    .parity_enable(parity_enable),
    .parity_type(parity_type),
    .prescale(prescale),
    .tx_ready(tx_ready),
    .busy(busy),
    .tx_out(tx_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame slot b (0 = start).
  function automatic logic exp_bit(input logic [7:0] d, input logic pe, input logic pt,
                                   input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe && b == 9) return (^d) ^ pt;
    return 1'b1;
  endfunction

  task automatic start_word(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [5:0] ps);
    @(negedge clk);
    tx_data       = d;
    parity_enable = pe;
    parity_type   = pt;
    prescale      = ps;
    data_valid    = 1'b1;
  endtask

  // Checks every cycle of a frame accepted on the preceding posedge, then the
  // single idle cycle after it. chain=1 keeps data_valid high and swaps in
  // the nxt_* word/config while busy.
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps, input bit chain, input string tag);
    int p;
    int nb;
    p  = (ps == 0) ? 1 : int'(ps);
    nb = 10 + int'(pe);
    for (int i = 0; i < p * nb; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (chain) begin
          tx_data       = nxt_data;
          parity_enable = nxt_pe;
          parity_type   = nxt_pt;
          prescale      = nxt_ps;
        end else begin
          data_valid = 1'b0;
        end
      end
      chk({tag, " bit"}, tx_out, exp_bit(d, pe, pt, i / p));
      chk({tag, " ready"}, tx_ready, 0);
      chk({tag, " busy"}, busy, 1);
    end
    @(negedge clk);
    chk({tag, " idle line"}, tx_out, 1);
    chk({tag, " idle ready"}, tx_ready, 1);
    chk({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] rx;
    logic       pe;
    logic       pt;
    logic       pb;
    logic       perr;
    logic [5:0] ps;
    int         p;
    int         t;

    rst_n = 1'b0; tx_data = '0; data_valid = 1'b0;
    parity_enable = 1'b0; parity_type = 1'b0; prescale = '0;

    // 1. Reset and quiet idle.
    repeat (3) @(negedge clk);
    chk("reset line", tx_out, 1);
    chk("reset ready", tx_ready, 1);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle line", tx_out, 1);
      chk("idle ready", tx_ready, 1);
      chk("idle busy", busy, 0);
    end

    // 2. 0xA5 even parity, prescale 8 (88 cycles, parity bit 0).
    start_word(8'hA5, 1'b1, 1'b0, 6'd8);
    check_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, "a5 even");

    // 3. 0xA5 odd parity, prescale 16 (176 cycles, parity bit 1).
    start_word(8'hA5, 1'b1, 1'b1, 6'd16);
    check_frame(8'hA5, 1'b1, 1'b1, 6'd16, 1'b0, "a5 odd");

    // 4. 0x01 no parity, prescale 0 treated as 1.
    start_word(8'h01, 1'b0, 1'b0, 6'd0);
    check_frame(8'h01, 1'b0, 1'b0, 6'd0, 1'b0, "01 p0");

    // 5. Back-to-back: valid held, second word/config applied while busy.
    nxt_data = 8'hC3; nxt_pe = 1'b0; nxt_pt = 1'b1; nxt_ps = 6'd3;
    start_word(8'h3C, 1'b1, 1'b0, 6'd2);
    check_frame(8'h3C, 1'b1, 1'b0, 6'd2, 1'b1, "b2b 3c");
    check_frame(8'hC3, 1'b0, 1'b1, 6'd3, 1'b0, "b2b c3");

    // 6. Reset during data bit 3, then a clean frame.
    start_word(8'h5A, 1'b0, 1'b0, 6'd4);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
      chk("pre-abort bit", tx_out, exp_bit(8'h5A, 1'b0, 1'b0, i / 4));
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort line", tx_out, 1);
    chk("abort ready", tx_ready, 1);
    chk("abort busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-abort idle", tx_out, 1);
    start_word(8'h96, 1'b1, 1'b1, 6'd5);
    check_frame(8'h96, 1'b1, 1'b1, 6'd5, 1'b0, "post-abort");

    // 7. Random loopback through a mid-bit sampling receiver model.
    for (int w = 0; w < 256; w++) begin
      d  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       ps = 6'd8;
        1:       ps = 6'd16;
        default: ps = 6'd32;
      endcase
      p = int'(ps);
      start_word(d, pe, pt, ps);
      @(negedge clk);
      data_valid = 1'b0;
      t = 0;
      while (tx_out !== 1'b0 && t < 8) begin
        @(negedge clk);
        t++;
      end
      chk("lb start seen", tx_out, 0);
      repeat (p / 2) @(negedge clk);
      chk("lb start mid", tx_out, 0);
      rx = '0;
      for (int k = 0; k < 8; k++) begin
        repeat (p) @(negedge clk);
        rx[k] = tx_out;
      end
      pb = 1'b0;
      if (pe) begin
        repeat (p) @(negedge clk);
        pb = tx_out;
      end
      repeat (p) @(negedge clk);
      chk("lb stop", tx_out, 1);
      perr = pe && (((^rx) ^ pb) != pt);
      chk("lb data", rx, d);
      chk("lb parity_error", perr, 0);
      t = 0;
      while (tx_ready !== 1'b1 && t < 2 * p) begin
        @(negedge clk);
        t++;
      end
      chk("lb ready", tx_ready, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
